tx_frame_scheduler: RTL

- Sequences the TX lane datapath (the data controller) by choosing, every cycle, which ordered set or data word it emits.
- Wraps user AXI-Stream frames in start/end-of-channel-PDU markers (SCP/ECP) and inserts clock-compensation (CC) sequences periodically.
- Throttles the user stream via tready.
- Sits between the user AXI-Stream slave and the per-lane data controller, downstream of channel initialisation.

---
 rtl/tx_frame_scheduler_pkg.sv | 29 ++
 rtl/tx_frame_scheduler_cc_timer.sv | 50 +++++
 rtl/tx_frame_scheduler.sv | 97 +++++++++
 3 files changed

// File: rtl/tx_frame_scheduler_pkg.sv
// Shared types and defaults for the TX frame scheduler.
package tx_frame_scheduler_pkg;

    localparam int CC_PERIOD_DEF = 5000;
    localparam int CC_LEN_DEF    = 12;

    typedef enum logic [2:0] {
        OS_IDLE = 3'd0,
        OS_CC   = 3'd1,
        OS_SCP  = 3'd2,
        OS_ECP  = 3'd3,
        OS_DATA = 3'd4
    } tx_os_t;

    typedef tx_os_t ordered_sets_t;

    typedef enum logic [2:0] {
        ST_DOWN = 3'd0,
        ST_IDLE = 3'd1,
        ST_SCP  = 3'd2,
        ST_DATA = 3'd3,
        ST_ECP  = 3'd4
    } tx_state_t;

    function automatic logic in_frame(tx_state_t s);
        return (s == ST_SCP) || (s == ST_DATA) || (s == ST_ECP);
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_cc_timer.sv
// Clock-compensation timer: period counter and CC length counter.
module tx_frame_scheduler_cc_timer #(
    parameter int PERIOD = 5000,
    parameter int LEN    = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic cc_active,
    output logic wrap
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int LW = (LEN > 1) ? $clog2(LEN) : 1;

    logic [CW-1:0] cnt;
    logic [LW-1:0] len_cnt;

    // clear outranks a wrap in the same cycle, so a lost channel never starts a CC
    assign wrap = enable && !clear && (cnt == CW'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            len_cnt   <= '0;
            cc_active <= 1'b0;
        end else if (clear) begin
            cnt       <= '0;
            len_cnt   <= '0;
            cc_active <= 1'b0;
        end else begin
            if (enable) begin
                cnt <= wrap ? '0 : cnt + CW'(1);
            end
            if (wrap) begin
                cc_active <= 1'b1;
                len_cnt   <= '0;
            end else if (cc_active) begin
                if (len_cnt == LW'(LEN - 1)) begin
                    cc_active <= 1'b0;
                    len_cnt   <= '0;
                end else begin
                    len_cnt <= len_cnt + LW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// TX frame scheduler: SCP/DATA/ECP framing with periodic CC insertion.
// Optional counters frame_cnt/cc_cnt are enabled by AURORA_TX_STATS_EN.
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int CC_PERIOD = CC_PERIOD_DEF,
    parameter int CC_LEN    = CC_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        channel_init_finished,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output tx_os_t      os_sel,
    output logic        frame_active,
    output logic        cc_active
`ifdef AURORA_TX_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] cc_cnt
`endif
);

    tx_state_t state;
    logic      cc_enable;
    logic      cc_clear;
    logic      cc_wrap;

    assign cc_enable = (state != ST_DOWN);
    assign cc_clear  = !channel_init_finished;

    tx_frame_scheduler_cc_timer #(
        .PERIOD (CC_PERIOD),
        .LEN    (CC_LEN)
    ) u_cc_timer (
        .clk       (clk),
        .rst       (rst),
        .enable    (cc_enable),
        .clear     (cc_clear),
        .cc_active (cc_active),
        .wrap      (cc_wrap)
    );

    // A running CC freezes the FSM; channel loss overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_DOWN;
        end else if (!channel_init_finished) begin
            state <= ST_DOWN;
        end else if (!cc_active) begin
            unique case (state)
                ST_DOWN: state <= ST_IDLE;
                ST_IDLE: if (s_tvalid) state <= ST_SCP;
                ST_SCP:  state <= ST_DATA;
                ST_DATA: if (s_tvalid && s_tlast) state <= ST_ECP;
                ST_ECP:  state <= ST_IDLE;
                default: state <= ST_DOWN;
            endcase
        end
    end

    always_comb begin
        os_sel       = OS_IDLE;
        s_tready     = 1'b0;
        frame_active = in_frame(state);
        unique case (state)
            ST_SCP:  os_sel = OS_SCP;
            ST_ECP:  os_sel = OS_ECP;
            ST_DATA: begin
                s_tready = 1'b1;
                os_sel   = s_tvalid ? OS_DATA : OS_IDLE;
            end
            default: os_sel = OS_IDLE;
        endcase
        if (cc_active) begin
            os_sel   = OS_CC;
            s_tready = 1'b0;
        end
    end

`ifdef AURORA_TX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            cc_cnt    <= '0;
        end else begin
            if (state == ST_ECP && !cc_active) frame_cnt <= frame_cnt + 16'd1;
            if (cc_wrap) cc_cnt <= cc_cnt + 16'd1;
        end
    end
`else
    logic unused_cc_wrap;
    assign unused_cc_wrap = cc_wrap;
`endif

endmodule
